// File: rtl/processing_unit_generic.sv
// Union-find decoder processing element for one lattice vertex: cluster root/parity merge,
// peeling with boundary-directed odd propagation, merge-quiet busy debounce and error counting.
module processing_unit_generic #(
    parameter int ADDRESS_WIDTH              = 6,
    parameter int NEIGHBOR_COUNT             = 6,
    parameter int ADDRESS                    = 0,
    parameter int IS_STREAMING_WINDOW_BORDER = 0,
    parameter int MERGE_QUIET_CYCLES         = 2,
    parameter int ERR_CNT_WIDTH              = 4,
    parameter int STAGE_WIDTH                = 3
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [STAGE_WIDTH-1:0]                         global_stage,
    input  logic                                           measurement,
    input  logic                                           has_correction,
    input  logic [NEIGHBOR_COUNT-1:0]                      neighbor_fully_grown,
    input  logic [NEIGHBOR_COUNT-1:0]                      neighbor_is_boundary,
    input  logic [NEIGHBOR_COUNT*(ADDRESS_WIDTH+7)-1:0]    input_data,
    output logic                                           measurement_out,
    output logic                                           neighbor_increase,
    output logic [NEIGHBOR_COUNT-1:0]                      neighbor_is_error,
    output logic [NEIGHBOR_COUNT*(ADDRESS_WIDTH+7)-1:0]    output_data,
    output logic [ADDRESS_WIDTH-1:0]                       root,
    output logic                                           odd,
    output logic                                           busy,
    output logic                                           peel_done,
    output logic [ERR_CNT_WIDTH-1:0]                       error_count
);
    localparam int N   = NEIGHBOR_COUNT;
    localparam int AW  = ADDRESS_WIDTH;
    localparam int EDS = AW + 7;
    localparam int F_PARENT = AW;
    localparam int F_ODD    = AW + 1;
    localparam int F_PAR    = AW + 2;
    localparam int F_BND    = AW + 3;
    localparam int F_PCOMP  = AW + 4;
    localparam int F_PM     = AW + 5;
    localparam int F_PDONE  = AW + 6;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                 = STAGE_WIDTH'(0);
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING  = STAGE_WIDTH'(1);
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                 = STAGE_WIDTH'(2);
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE                = STAGE_WIDTH'(3);
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING              = STAGE_WIDTH'(4);
    localparam logic [STAGE_WIDTH-1:0] STAGE_STREAMING_CORRECTION = STAGE_WIDTH'(5);

    localparam logic [3:0]               QUIET_MAX = 4'(MERGE_QUIET_CYCLES);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX   = '1;

    function automatic logic [N-1:0] lowest_bit(input logic [N-1:0] v);
        return v & (~v + {{(N-1){1'b0}}, 1'b1});
    endfunction

    logic [STAGE_WIDTH-1:0] stage, last_stage;
    logic                   m, cluster_parity, touching_boundary;
    logic                   peel_m, peel_complete, parity_completed, counted;
    logic [N-1:0]           parent_vector, odd_to_children;
    logic [3:0]             quiet_cnt;

    logic [AW-1:0] nb_root [N];
    logic [N-1:0]  nb_parent, nb_odd, nb_par, nb_bnd, nb_pcomp, nb_pm, nb_pdone;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            nb_root[i]   = input_data[i*EDS +: AW];
            nb_parent[i] = input_data[i*EDS + F_PARENT];
            nb_odd[i]    = input_data[i*EDS + F_ODD];
            nb_par[i]    = input_data[i*EDS + F_PAR];
            nb_bnd[i]    = input_data[i*EDS + F_BND];
            nb_pcomp[i]  = input_data[i*EDS + F_PCOMP];
            nb_pm[i]     = input_data[i*EDS + F_PM];
            nb_pdone[i]  = input_data[i*EDS + F_PDONE];
        end
    end

    always_comb begin
        output_data = '0;
        for (int i = 0; i < N; i++) begin
            output_data[i*EDS +: AW]        = root;
            output_data[i*EDS + F_PARENT]   = parent_vector[i];
            output_data[i*EDS + F_ODD]      = odd_to_children[i];
            output_data[i*EDS + F_PAR]      = cluster_parity;
            output_data[i*EDS + F_BND]      = touching_boundary;
            output_data[i*EDS + F_PCOMP]    = peel_complete;
            output_data[i*EDS + F_PM]       = peel_m;
            output_data[i*EDS + F_PDONE]    = parity_completed;
        end
    end

    logic [N-1:0]  candidates, child_vec, best_oh, parent_nx, otc_peel;
    logic [AW-1:0] root_nx;
    logic          is_root, par_nx, bnd_nx, odd_merge, changed, parent_odd;
    logic          peel_first, all_cc, pc_nx, peel_odd_in, peel_m_nx, complete_now;
    logic [3:0]    quiet_inc;
    logic [7:0]    err_pop;
    logic [ERR_CNT_WIDTH+7:0] err_sum;
    logic [ERR_CNT_WIDTH-1:0] err_sat;

    // Merge: adopt the smallest neighbouring root over non-boundary grown edges.
    always_comb begin
        candidates = neighbor_fully_grown & ~neighbor_is_boundary;
        child_vec  = candidates & nb_parent;
        is_root    = ~|parent_vector;
        parent_odd = |(parent_vector & nb_odd);
        root_nx    = root;
        best_oh    = '0;
        for (int i = 0; i < N; i++) begin
            if (candidates[i] && (nb_root[i] < root_nx)) begin
                root_nx    = nb_root[i];
                best_oh    = '0;
                best_oh[i] = 1'b1;
            end
        end
        parent_nx = (|best_oh) ? best_oh : parent_vector;
        par_nx    = m ^ (^(child_vec & nb_par));
        bnd_nx    = (|(child_vec & nb_bnd)) | (|neighbor_is_boundary);
        odd_merge = is_root ? (par_nx & ~bnd_nx) : parent_odd;
        changed   = (root_nx != root) || (par_nx != cluster_parity) ||
                    (bnd_nx != touching_boundary) || (odd_merge != odd);
        quiet_inc = (quiet_cnt == QUIET_MAX) ? quiet_cnt : quiet_cnt + 4'd1;
    end

    // Peeling: odd flows from the root toward the boundary along boundary-touching children.
    always_comb begin
        peel_first   = (stage == STAGE_PEELING) && (last_stage != STAGE_PEELING);
        all_cc       = &(~child_vec | nb_pcomp);
        pc_nx        = is_root | (|(parent_vector & nb_pdone));
        peel_odd_in  = is_root ? (cluster_parity & touching_boundary) : parent_odd;
        otc_peel     = (peel_odd_in && !(|neighbor_is_boundary)) ?
                       lowest_bit(child_vec & nb_bnd) : '0;
        peel_m_nx    = m ^ (^(child_vec & nb_pm)) ^ odd;
        neighbor_is_error = '0;
        if (((stage == STAGE_PEELING) || (stage == STAGE_STREAMING_CORRECTION)) && all_cc)
            neighbor_is_error = (child_vec & nb_pm) |
                                (odd ? lowest_bit(neighbor_is_boundary) : '0);
        complete_now = (stage == STAGE_PEELING) && !peel_first && all_cc &&
                       parity_completed && !counted;
        err_pop = '0;
        for (int i = 0; i < N; i++)
            err_pop = err_pop + 8'(neighbor_is_error[i]);
        err_sum = {8'b0, error_count} + (ERR_CNT_WIDTH+8)'(err_pop);
        err_sat = (err_sum > {8'b0, ERR_MAX}) ? ERR_MAX : err_sum[ERR_CNT_WIDTH-1:0];
    end

    assign neighbor_increase = odd && (stage == STAGE_GROW) && (last_stage != STAGE_GROW);
    assign measurement_out   = m;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage             <= STAGE_IDLE;
            last_stage        <= STAGE_IDLE;
            m                 <= 1'b0;
            odd               <= 1'b0;
            busy              <= 1'b0;
            peel_done         <= 1'b0;
            counted           <= 1'b0;
            root              <= AW'(ADDRESS);
            parent_vector     <= '0;
            odd_to_children   <= '0;
            cluster_parity    <= 1'b0;
            touching_boundary <= 1'b0;
            peel_m            <= 1'b0;
            peel_complete     <= 1'b0;
            parity_completed  <= 1'b0;
            quiet_cnt         <= '0;
            error_count       <= '0;
        end else begin
            stage      <= global_stage;
            last_stage <= stage;
            case (stage)
                STAGE_MEASUREMENT_LOADING: begin
                    m                 <= measurement;
                    odd               <= measurement;
                    cluster_parity    <= measurement;
                    odd_to_children   <= {N{measurement}};
                    root              <= AW'(ADDRESS);
                    parent_vector     <= '0;
                    touching_boundary <= 1'b0;
                    peel_m            <= 1'b0;
                    peel_complete     <= 1'b0;
                    parity_completed  <= 1'b0;
                    peel_done         <= 1'b0;
                    counted           <= 1'b0;
                    error_count       <= '0;
                    quiet_cnt         <= '0;
                    busy              <= 1'b1;
                end
                STAGE_MERGE: begin
                    root              <= root_nx;
                    parent_vector     <= parent_nx;
                    cluster_parity    <= par_nx;
                    touching_boundary <= bnd_nx;
                    odd               <= odd_merge;
                    odd_to_children   <= {N{odd_merge}};
                    if (changed) begin
                        quiet_cnt <= '0;
                        busy      <= 1'b1;
                    end else begin
                        quiet_cnt <= quiet_inc;
                        busy      <= (quiet_inc != QUIET_MAX);
                    end
                end
                STAGE_PEELING: begin
                    parity_completed <= pc_nx;
                    odd              <= peel_odd_in;
                    odd_to_children  <= otc_peel;
                    busy             <= ~all_cc;
                    // counted re-arms every peel round; peel_done stays sticky until loading
                    if (peel_first) begin
                        peel_m        <= m;
                        peel_complete <= 1'b0;
                        counted       <= 1'b0;
                    end else if (all_cc) begin
                        peel_m        <= peel_m_nx;
                        peel_complete <= 1'b1;
                    end
                    if (complete_now) begin
                        peel_done   <= 1'b1;
                        counted     <= 1'b1;
                        error_count <= err_sat;
                    end
                end
                STAGE_STREAMING_CORRECTION: begin
                    if ((IS_STREAMING_WINDOW_BORDER != 0) && has_correction)
                        m <= measurement;
                end
                default: ;
            endcase
        end
    end
endmodule
